// File: rtl/xillybus_mem8_pkg.sv
// Shared widths and types for the xillybus mem_8 register bank.
package xillybus_mem8_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef logic [ADDR_W_DEF-1:0] ptr_t;
    typedef logic [7:0]            byte_t;

endpackage

// File: rtl/xillybus_mem8_dpram.sv
// Two-port byte RAM, synchronous read-before-write on both ports.
import xillybus_mem8_pkg::*;

module xillybus_mem8_dpram #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic              a_re,
    input  byte_t             a_wdata,
    output byte_t             a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  byte_t             b_wdata,
    output byte_t             b_rdata
);

    byte_t mem [2**ADDR_W];
    byte_t a_rdata_reg;
    byte_t b_rdata_reg;

    // Port A is written last so it wins should both ever target one address.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            if (a_re) begin
                a_rdata_reg <= mem[a_addr];
            end
            b_rdata_reg <= mem[b_addr];
        end
    end

    assign a_rdata = a_rdata_reg;
    assign b_rdata = b_rdata_reg;

endmodule

// File: rtl/xillybus_mem8_bank.sv
// Seekable byte bank behind /dev/xillybus_mem_8 with a fabric access port
// and a host-write counter.
import xillybus_mem8_pkg::*;

module xillybus_mem8_bank #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              user_w_mem_8_wren,
    input  byte_t             user_w_mem_8_data,
    output logic              user_w_mem_8_full,
    input  logic              user_w_mem_8_open,
    input  logic              user_r_mem_8_rden,
    output byte_t             user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    input  logic [ADDR_W-1:0] fab_addr,
    input  logic              fab_wren,
    input  byte_t             fab_wdata,
    output byte_t             fab_rdata,
    output logic [CNT_W-1:0]  host_wr_count,
    output logic              host_wr_pulse
);

    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] ea;
    logic              step;
    logic              host_we;
    logic              fab_we;
    logic              open_d_reg;
    logic              open_rise;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              pulse_reg;
    logic              unused_r_open;

    assign user_w_mem_8_full  = 1'b0;
    assign user_r_mem_8_empty = 1'b0;
    assign user_r_mem_8_eof   = 1'b0;
    assign unused_r_open      = user_r_mem_8_open;

    assign ea   = user_mem_8_addr_update ? user_mem_8_addr : ptr_reg;
    assign step = user_w_mem_8_wren | user_r_mem_8_rden;

    // Writes are suppressed while reset is held so a reset aborts the access.
    assign host_we = user_w_mem_8_wren & bus_rst_n;
    assign fab_we  = fab_wren & bus_rst_n & ~(user_w_mem_8_wren && (fab_addr == ea));

    assign open_rise = user_w_mem_8_open & ~open_d_reg;

    always_comb begin
        ptr_next = ptr_reg;
        if (user_mem_8_addr_update || step) begin
            ptr_next = ea + {{(ADDR_W-1){1'b0}}, step};
        end
    end

    always_comb begin
        count_next = count_reg;
        if (open_rise) begin
            count_next = user_w_mem_8_wren ? CNT_W'(1) : '0;
        end else if (user_w_mem_8_wren && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            ptr_reg    <= '0;
            open_d_reg <= 1'b0;
            count_reg  <= '0;
            pulse_reg  <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            open_d_reg <= user_w_mem_8_open;
            count_reg  <= count_next;
            pulse_reg  <= user_w_mem_8_wren;
        end
    end

    assign host_wr_count = count_reg;
    assign host_wr_pulse = pulse_reg;

    xillybus_mem8_dpram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (bus_clk),
        .rst_n   (bus_rst_n),
        .a_addr  (ea),
        .a_we    (host_we),
        .a_re    (user_r_mem_8_rden),
        .a_wdata (user_w_mem_8_data),
        .a_rdata (user_r_mem_8_data),
        .b_addr  (fab_addr),
        .b_we    (fab_we),
        .b_wdata (fab_wdata),
        .b_rdata (fab_rdata)
    );

endmodule

// File: tb/tb_xillybus_mem8_bank.sv
// Directed bench for xillybus_mem8_bank: seek/read/write, wrap, collisions,
// counter clear and saturation, reset mid-burst.
module tb_xillybus_mem8_bank;

    logic        bus_clk = 1'b0;
    logic        bus_rst_n = 1'b0;
    logic        wren = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        w_open = 1'b0;
    logic        rden = 1'b0;
    logic        r_open = 1'b0;
    logic [4:0]  seek_addr = 5'd0;
    logic        addr_update = 1'b0;
    logic [4:0]  fab_addr = 5'd0;
    logic        fab_wren = 1'b0;
    logic [7:0]  fab_wdata = 8'h00;

    logic        full_a, empty_a, eof_a, pulse_a;
    logic [7:0]  rdata_a, fab_rdata_a;
    logic [15:0] count_a;
    logic        full_c, empty_c, eof_c, pulse_c;
    logic [7:0]  rdata_c, fab_rdata_c;
    logic [2:0]  count_c;

    int checks = 0;
    int errors = 0;

    always #5 bus_clk = ~bus_clk;

    xillybus_mem8_bank dut (
        .bus_clk                (bus_clk),
        .bus_rst_n              (bus_rst_n),
        .user_w_mem_8_wren      (wren),
        .user_w_mem_8_data      (wdata),
        .user_w_mem_8_full      (full_a),
        .user_w_mem_8_open      (w_open),
        .user_r_mem_8_rden      (rden),
        .user_r_mem_8_data      (rdata_a),
        .user_r_mem_8_empty     (empty_a),
        .user_r_mem_8_eof       (eof_a),
        .user_r_mem_8_open      (r_open),
        .user_mem_8_addr        (seek_addr),
        .user_mem_8_addr_update (addr_update),
        .fab_addr               (fab_addr),
        .fab_wren               (fab_wren),
        .fab_wdata              (fab_wdata),
        .fab_rdata              (fab_rdata_a),
        .host_wr_count          (count_a),
        .host_wr_pulse          (pulse_a)
    );

    xillybus_mem8_bank #(.ADDR_W(5), .CNT_W(3)) dut_c3 (
        .bus_clk                (bus_clk),
        .bus_rst_n              (bus_rst_n),
        .user_w_mem_8_wren      (wren),
        .user_w_mem_8_data      (wdata),
        .user_w_mem_8_full      (full_c),
        .user_w_mem_8_open      (w_open),
        .user_r_mem_8_rden      (rden),
        .user_r_mem_8_data      (rdata_c),
        .user_r_mem_8_empty     (empty_c),
        .user_r_mem_8_eof       (eof_c),
        .user_r_mem_8_open      (r_open),
        .user_mem_8_addr        (seek_addr),
        .user_mem_8_addr_update (addr_update),
        .fab_addr               (fab_addr),
        .fab_wren               (fab_wren),
        .fab_wdata              (fab_wdata),
        .fab_rdata              (fab_rdata_c),
        .host_wr_count          (count_c),
        .host_wr_pulse          (pulse_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic seek(input logic [4:0] a);
        seek_addr   = a;
        addr_update = 1'b1;
        tick();
        addr_update = 1'b0;
    endtask

    task automatic hwrite(input logic [7:0] d);
        wren  = 1'b1;
        wdata = d;
        tick();
        wren  = 1'b0;
    endtask

    task automatic hread(input string tag, input logic [7:0] exp);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        check_eq(tag, {24'h0, rdata_a}, {24'h0, exp});
    endtask

    task automatic fab_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
        fab_addr = a;
        tick();
        check_eq(tag, {24'h0, fab_rdata_a}, {24'h0, exp});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_rdata", {24'h0, rdata_a}, 32'h0);
        check_eq("rst_fab_rdata", {24'h0, fab_rdata_a}, 32'h0);
        check_eq("rst_count", {16'h0, count_a}, 32'h0);
        check_eq("rst_pulse", {31'h0, pulse_a}, 32'h0);
        check_eq("tieoffs", {29'h0, full_a, empty_a, eof_a}, 32'h0);
        bus_rst_n = 1'b1;
        r_open    = 1'b1;

        w_open = 1'b1;
        tick();
        check_eq("open_count", {16'h0, count_a}, 32'h0);

        // Seek 3, write three bytes, read them back
        seek(5'd3);
        hwrite(8'hA1);
        check_eq("pulse_hi", {31'h0, pulse_a}, 32'h1);
        hwrite(8'hA2);
        hwrite(8'hA3);
        tick();
        check_eq("pulse_lo", {31'h0, pulse_a}, 32'h0);
        check_eq("count_3", {16'h0, count_a}, 32'd3);
        seek(5'd3);
        hread("rd_3", 8'hA1);
        hread("rd_4", 8'hA2);
        hread("rd_5", 8'hA3);
        tick();
        check_eq("rdata_hold", {24'h0, rdata_a}, 32'hA3);
        hwrite(8'h77);
        fab_check("ptr_was_6", 5'd6, 8'h77);

        // Wrap from 31 to 0
        seek(5'd31);
        hwrite(8'h55);
        hwrite(8'h66);
        hwrite(8'h12);
        fab_check("wrap_31", 5'd31, 8'h55);
        fab_check("wrap_0", 5'd0, 8'h66);
        fab_check("ptr_was_1", 5'd1, 8'h12);
        check_eq("count_7", {16'h0, count_a}, 32'd7);
        check_eq("count_c3_7", {29'h0, count_c}, 32'd7);

        // Seek and write in one cycle
        seek_addr   = 5'd7;
        addr_update = 1'b1;
        hwrite(8'h9C);
        addr_update = 1'b0;
        hwrite(8'h88);
        fab_check("seek_wr_7", 5'd7, 8'h9C);
        fab_check("ptr_was_8", 5'd8, 8'h88);

        // Simultaneous read and write returns the old byte
        seek(5'd4);
        hwrite(8'h11);
        seek(5'd4);
        wren  = 1'b1;
        wdata = 8'h22;
        hread("rbw_old", 8'h11);
        wren  = 1'b0;
        hwrite(8'h35);
        fab_check("rbw_new", 5'd4, 8'h22);
        fab_check("ptr_was_5", 5'd5, 8'h35);

        // Same-address collision: host wins
        seek(5'd9);
        fab_addr  = 5'd9;
        fab_wren  = 1'b1;
        fab_wdata = 8'hBB;
        hwrite(8'hAA);
        fab_wren  = 1'b0;
        tick();
        check_eq("collide_host_wins", {24'h0, fab_rdata_a}, 32'hAA);

        // Different addresses: both stored
        seek(5'd10);
        fab_addr  = 5'd11;
        fab_wren  = 1'b1;
        fab_wdata = 8'hC2;
        hwrite(8'hC1);
        fab_wren  = 1'b0;
        fab_check("dual_host", 5'd10, 8'hC1);
        fab_check("dual_fab", 5'd11, 8'hC2);
        check_eq("count_14", {16'h0, count_a}, 32'd14);

        // Re-open clears the counter; then saturation on the narrow counter
        w_open = 1'b0;
        tick();
        w_open = 1'b1;
        tick();
        check_eq("reopen_clear", {16'h0, count_a}, 32'd0);
        check_eq("reopen_clear_c3", {29'h0, count_c}, 32'd0);
        seek(5'd16);
        for (int i = 0; i < 5; i++) hwrite(8'h40 + 8'(i));
        check_eq("count_5", {16'h0, count_a}, 32'd5);
        for (int i = 0; i < 4; i++) hwrite(8'h50 + 8'(i));
        check_eq("count_9", {16'h0, count_a}, 32'd9);
        check_eq("count_c3_sat", {29'h0, count_c}, 32'd7);

        // Open edge coinciding with a write leaves count at 1
        w_open = 1'b0;
        tick();
        w_open = 1'b1;
        hwrite(8'h60);
        check_eq("clear_and_wr", {16'h0, count_a}, 32'd1);
        check_eq("clear_and_wr_c3", {29'h0, count_c}, 32'd1);

        // Reset in the middle of a write burst
        seek(5'd20);
        wren  = 1'b1;
        wdata = 8'h01;
        tick();
        wdata     = 8'h02;
        bus_rst_n = 1'b0;
        tick();
        wren      = 1'b0;
        bus_rst_n = 1'b1;
        check_eq("midrst_rdata", {24'h0, rdata_a}, 32'h0);
        check_eq("midrst_count", {16'h0, count_a}, 32'h0);
        check_eq("midrst_pulse", {31'h0, pulse_a}, 32'h0);
        hread("midrst_ptr0", 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
